// File: rtl/ps2_rx_pkg.sv
// ps2_rx_pkg: shared FSM states, error codes and parity modes for the PS/2 frame receiver.
package ps2_rx_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    localparam logic [1:0] ERR_FRAMING  = 2'd0;
    localparam logic [1:0] ERR_PARITY   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // ones_odd is the XOR of all data bits and the received parity bit
    function automatic logic parity_bad(input logic ones_odd, input int mode);
        return (mode == PAR_ODD) ? ~ones_odd : (mode == PAR_EVEN) ? ones_odd : 1'b0;
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: synchronous FIFO with registered head, push/pop/clear and level output.
module ps2_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [LW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign full_o     = cnt_q == LW'(DEPTH);
    assign empty_o    = cnt_q == '0;
    assign level_o    = cnt_q;
    assign pop_data_o = mem_q[rd_q];
    assign do_pop     = pop_i & ~empty_o;
    // a pop in the same cycle frees the slot the push needs
    assign do_push    = push_i & (~full_o | do_pop);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver: PS/2 frame deserialiser with output FIFO and error reporting.
// Optional device_clock glitch filter enabled by defining PS2_RX_GLITCH_FILTER_EN.
module ps2_frame_receiver
    import ps2_rx_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int PARITY_MODE   = 1,
    parameter int TIMEOUT       = 1000,
    parameter int FIFO_DEPTH    = 4,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            peripheral_clock,
    input  logic                            device_clock,
    input  logic                            device_data,
    input  logic                            clear,
    output logic [DATA_WIDTH-1:0]           rx_data,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            error_flag,
    output logic [1:0]                      error_code,
    output logic                            busy
);

    localparam int CW = $clog2(DATA_WIDTH+1);

    logic [1:0]            dclk_q, ddat_q;
    logic [2:0]            pclk_q;
    logic                  lvl, lvl_prev_q, strobe, tick, sdata;
    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_q;
    logic [15:0]           timer_q;
    logic                  err_q;
    logic [1:0]            code_q;
    logic                  timeout, stop_hit, par_bad, framing, parity_err, push, overflow;
    logic                  full, empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            dclk_q     <= '0;
            ddat_q     <= '0;
            pclk_q     <= '0;
            lvl_prev_q <= 1'b0;
        end else begin
            dclk_q     <= {dclk_q[0], device_clock};
            ddat_q     <= {ddat_q[0], device_data};
            pclk_q     <= {pclk_q[1:0], peripheral_clock};
            lvl_prev_q <= lvl;
        end
    end

`ifdef PS2_RX_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_CYCLES+1);
    logic          flt_q;
    logic [FW-1:0] flt_cnt_q;

    // level flips only after FILTER_CYCLES consecutive cycles at the new value
    always_ff @(posedge clock) begin
        if (reset) begin
            flt_q     <= 1'b0;
            flt_cnt_q <= '0;
        end else if (dclk_q[1] == flt_q) begin
            flt_cnt_q <= '0;
        end else if (flt_cnt_q == FW'(FILTER_CYCLES-1)) begin
            flt_q     <= dclk_q[1];
            flt_cnt_q <= '0;
        end else begin
            flt_cnt_q <= flt_cnt_q + 1'b1;
        end
    end

    assign lvl = flt_q;
`else
    logic unused_filter;
    assign unused_filter = ^FILTER_CYCLES;
    assign lvl           = dclk_q[1];
`endif

    assign strobe     = lvl_prev_q & ~lvl;
    assign tick       = pclk_q[1] & ~pclk_q[2];
    assign sdata      = ddat_q[1];
    assign timeout    = (state_q != IDLE) && (timer_q == 16'(TIMEOUT));
    assign stop_hit   = (state_q == STOP) && strobe && !timeout;
    assign par_bad    = parity_bad(^shift_q ^ par_q, PARITY_MODE);
    assign framing    = stop_hit & ~sdata;
    assign parity_err = stop_hit & sdata & par_bad;
    assign push       = stop_hit & sdata & ~par_bad;
    assign overflow   = push & full & ~rx_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            timer_q <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_FRAMING;
        end else if (clear) begin
            state_q <= IDLE;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= timeout | framing | parity_err | overflow;
            if (timeout | framing | parity_err | overflow)
                code_q <= timeout ? ERR_TIMEOUT : framing ? ERR_FRAMING :
                          parity_err ? ERR_PARITY : ERR_OVERFLOW;
            timer_q <= (state_q == IDLE || strobe) ? '0 :
                       (tick && timer_q != '1) ? timer_q + 1'b1 : timer_q;
            if (timeout) begin
                state_q <= IDLE;
                timer_q <= '0;
            end else if (strobe) begin
                case (state_q)
                    IDLE: if (!sdata) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                    end
                    DATA: begin
                        shift_q <= DATA_WIDTH'({sdata, shift_q} >> 1);
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == CW'(DATA_WIDTH-1))
                            state_q <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                    end
                    PARITY: begin
                        par_q   <= sdata;
                        state_q <= STOP;
                    end
                    STOP: state_q <= IDLE;
                endcase
            end
        end
    end

    ps2_rx_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock_i     (clock),
        .reset_i     (reset),
        .clear_i     (clear),
        .push_i      (push),
        .push_data_i (shift_q),
        .pop_i       (rx_ready),
        .pop_data_o  (rx_data),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (fifo_level)
    );

    assign rx_valid   = ~empty;
    assign error_flag = err_q;
    assign error_code = code_q;
    assign busy       = state_q != IDLE;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// tb_ps2_frame_receiver: directed table-driven bench for ps2_frame_receiver (8-bit odd and 9-bit no-parity builds).
module tb_ps2_frame_receiver;

    logic clk = 1'b0, rst = 1'b1, pclk = 1'b0, dclk = 1'b1, ddat = 1'b1, clr = 1'b0;
    logic rdy8 = 1'b0, rdy9 = 1'b0;
    logic [7:0] d8;
    logic [8:0] d9;
    logic [2:0] lvl8, lvl9;
    logic       v8, v9, ef8, ef9, busy8, busy9;
    logic [1:0] ec8, ec9;
    int errors = 0, checks = 0, e8_n = 0, e9_n = 0;
    logic [1:0] e8_c = 2'd0, e9_c = 2'd0;

`ifdef PS2_RX_GLITCH_FILTER_EN
    localparam int POP_WAIT = 6;
    localparam int GLITCH_AT = 4;
`else
    localparam int POP_WAIT = 2;
    localparam int GLITCH_AT = -1;
`endif

    always #5 clk = ~clk;
    always #20 pclk = ~pclk;

    ps2_frame_receiver dut (
        .clock(clk), .reset(rst), .peripheral_clock(pclk), .device_clock(dclk),
        .device_data(ddat), .clear(clr), .rx_data(d8), .rx_valid(v8), .rx_ready(rdy8),
        .fifo_level(lvl8), .error_flag(ef8), .error_code(ec8), .busy(busy8)
    );

    ps2_frame_receiver #(.DATA_WIDTH(9), .PARITY_MODE(0)) dut9 (
        .clock(clk), .reset(rst), .peripheral_clock(pclk), .device_clock(dclk),
        .device_data(ddat), .clear(clr), .rx_data(d9), .rx_valid(v9), .rx_ready(rdy9),
        .fifo_level(lvl9), .error_flag(ef9), .error_code(ec9), .busy(busy9)
    );

    always @(posedge clk) begin
        #1;
        if (ef8) begin e8_n++; e8_c = ec8; end
        if (ef9) begin e9_n++; e9_c = ec9; end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit pop, input bit glitch);
        ddat = b;
        if (glitch) begin
            @(negedge clk); dclk = 1'b0;
            repeat (2) @(negedge clk); dclk = 1'b1;
            repeat (2) @(negedge clk);
        end else repeat (5) @(negedge clk);
        dclk = 1'b0;
        if (pop) begin
            repeat (POP_WAIT) @(negedge clk); rdy8 = 1'b1;
            @(negedge clk); rdy8 = 1'b0;
            repeat (10 - POP_WAIT - 1) @(negedge clk);
        end else repeat (10) @(negedge clk);
        dclk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] d, input int nd, input bit use_p, input logic p,
                              input logic s, input bit pop_stop, input int glitch_at);
        send_bit(1'b0, 0, 0);
        for (int i = 0; i < nd; i++) send_bit(d[i], 0, i == glitch_at);
        if (use_p) send_bit(p, 0, 0);
        send_bit(s, pop_stop, 0);
        repeat (5) @(negedge clk);
    endtask

    task automatic pop8();
        rdy8 = 1'b1;
        @(negedge clk); rdy8 = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic op(input logic [7:0] d);
        return ~^d;
    endfunction

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic       ok;
        logic [1:0] code;
    } vec_t;

    vec_t tbl [9];
    logic [7:0] ov [4];
    int b0, cyc;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 2'd0};
        tbl[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 2'd1};
        tbl[2] = '{8'h1C, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[3] = '{8'h1C, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 2'd0};
        tbl[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 2'd0};
        tbl[6] = '{8'h00, 1'b0, 1'b1, 1'b0, 2'd1};
        tbl[7] = '{8'hA5, 1'b1, 1'b1, 1'b1, 2'd0};
        tbl[8] = '{8'h80, 1'b0, 1'b1, 1'b1, 2'd0};
        ov[0] = 8'h11; ov[1] = 8'h22; ov[2] = 8'h33; ov[3] = 8'h44;

        repeat (4) @(negedge clk);
        chk("reset rx_valid", v8, 0);
        chk("reset fifo_level", lvl8, 0);
        chk("reset error_flag", ef8, 0);
        chk("reset error_code", ec8, 0);
        chk("reset busy", busy8, 0);
        chk("reset rx_data", d8, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            b0 = e8_n;
            send_frame({8'h00, tbl[i].d}, 8, 1, tbl[i].p, tbl[i].s, 0, -1);
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d error count", i), e8_n - b0, tbl[i].ok ? 0 : 1);
            if (!tbl[i].ok) chk($sformatf("vec%0d error_code", i), e8_c, tbl[i].code);
            chk($sformatf("vec%0d fifo_level", i), lvl8, tbl[i].ok ? 1 : 0);
            chk($sformatf("vec%0d rx_valid", i), v8, tbl[i].ok);
            if (tbl[i].ok) chk($sformatf("vec%0d rx_data", i), d8, tbl[i].d);
            pop8();
            chk($sformatf("vec%0d level after pop", i), lvl8, 0);
        end

        b0 = e8_n;
        send_bit(1'b0, 0, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0, 0);
        chk("stall busy", busy8, 1);
        cyc = 0;
        while (e8_n == b0 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
        end
        chk("timeout fired", e8_n - b0, 1);
        chk("timeout error_code", e8_c, 2);
        chk("timeout latency in range", (cyc >= 3900 && cyc <= 4100) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
        chk("timeout busy low", busy8, 0);
        chk("timeout no push", lvl8, 0);
        b0 = e8_n;
        send_frame(16'h0055, 8, 1, op(8'h55), 1'b1, 0, -1);
        repeat (3) @(negedge clk);
        chk("post-timeout rx_data", d8, 8'h55);
        chk("post-timeout no error", e8_n - b0, 0);
        pop8();

        b0 = e8_n;
        for (int k = 0; k < 4; k++) send_frame({8'h00, ov[k]}, 8, 1, op(ov[k]), 1'b1, 0, -1);
        chk("fill level 4", lvl8, 4);
        chk("fill no error", e8_n - b0, 0);
        send_frame(16'h0099, 8, 1, op(8'h99), 1'b1, 0, -1);
        repeat (3) @(negedge clk);
        chk("overflow level", lvl8, 4);
        chk("overflow fired", e8_n - b0, 1);
        chk("overflow error_code", e8_c, 3);
        chk("overflow head held", d8, ov[0]);
        b0 = e8_n;
        send_frame(16'h0066, 8, 1, op(8'h66), 1'b1, 1, -1);
        repeat (3) @(negedge clk);
        chk("push with pop level", lvl8, 4);
        chk("push with pop no error", e8_n - b0, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d valid", k), v8, 1);
            chk($sformatf("drain%0d data", k), d8, (k < 3) ? ov[k+1] : 8'h66);
            pop8();
        end
        chk("drained level", lvl8, 0);
        chk("drained valid", v8, 0);
        pop8();
        chk("pop on empty level", lvl8, 0);

        send_frame(16'h003C, 8, 1, op(8'h3C), 1'b1, 0, -1);
        send_bit(1'b0, 0, 0);
        send_bit(1'b1, 0, 0);
        chk("pre-clear level", lvl8, 1);
        chk("pre-clear busy", busy8, 1);
        b0 = e8_n;
        clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        repeat (20) @(negedge clk);
        chk("clear level", lvl8, 0);
        chk("clear valid", v8, 0);
        chk("clear busy", busy8, 0);
        chk("clear no error", e8_n - b0, 0);

        b0 = e9_n;
        send_frame(16'h01A5, 9, 0, 1'b0, 1'b1, 0, GLITCH_AT);
        repeat (3) @(negedge clk);
        chk("w9 level", lvl9, 1);
        chk("w9 rx_data", d9, 9'h1A5);
        chk("w9 no error", e9_n - b0, 0);
        chk("w8 sees same bits", d8, 8'hA5);

        send_bit(1'b0, 0, 0);
        send_bit(1'b0, 0, 0);
        b0 = e8_n;
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid-frame reset busy", busy8, 0);
        chk("mid-frame reset level", lvl8, 0);
        chk("mid-frame reset no error", e8_n - b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
